// File: rtl/parity_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_rx_pkg
//  Description : Shared types and constants for the serial parity-frame
//                receiver: FSM state encoding and the line levels of the
//                start and stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_rx_pkg;

    // Receiver FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Line level that opens a frame
    localparam logic START_BIT = 1'b0;
    // Line level expected in the stop slot
    localparam logic STOP_BIT  = 1'b1;

endpackage : parity_rx_pkg
`default_nettype wire

// File: rtl/xor_acc.sv
`default_nettype none
// ============================================================================
//  Module      : xor_acc
//  Description : Running XOR parity accumulator. A clear loads the initial
//                value (the parity sense); otherwise every enabled bit is
//                folded into the accumulated value.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_acc (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic init,
    input  logic en,
    input  logic d,
    output logic q
);

    logic r_acc;

    // Accumulate parity; clear has priority so a new frame starts from init
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc <= 1'b0;
        end else if (clear) begin
            r_acc <= init;
        end else begin
            r_acc <= r_acc ^ (en & d);
        end
    end

    assign q = r_acc;

endmodule : xor_acc
`default_nettype wire

// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_rx
//  Description : Serial parity-frame receiver. Samples one line bit per
//                I_VALID strobe in the format start, DATA_W data bits (LSB
//                first), parity and stop. Rebuilds the word, checks parity
//                and hands the result to a one-deep valid/ready output
//                register. Frames arriving while the register is still
//                occupied are dropped and flagged in the sticky O_OVR.
//  Config      : PARITY_RX_STOP_CHK_EN defined   -> stop bit received and
//                                                  checked (O_FERR live)
//                PARITY_RX_STOP_CHK_EN undefined -> no stop slot, the frame
//                                                  commits in the parity
//                                                  slot and O_FERR is 0
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_rx #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I,
    input  logic              I_VALID,
    output logic [DATA_W-1:0] O_DATA,
    output logic              O_VALID,
    input  logic              O_READY,
    output logic              O_PERR,
    output logic              O_FERR,
    output logic              O_OVR
);

    import parity_rx_pkg::*;

    localparam int              CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;

    logic              w_acc_q;
    logic              w_acc_clear;
    logic              w_acc_en;

    logic              w_commit;
    logic              w_perr_commit;
    logic              w_ferr_commit;

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_perr;
    logic              r_ferr;
    logic              r_ovr;

    // ------------------------------------------------------------------------
    // Parity accumulator: seeded with the parity sense on the start bit so
    // that acc ^ parity_bit is 1 exactly when the frame parity is wrong.
    // ------------------------------------------------------------------------
    xor_acc u_xor_acc (
        .CLK   (CLK),
        .RST   (RST),
        .clear (w_acc_clear),
        .init  (ODD),
        .en    (w_acc_en),
        .d     (I),
        .q     (w_acc_q)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode; nothing moves without I_VALID
    always_comb begin
        w_state_nxt = r_state;
        w_acc_clear = 1'b0;
        w_acc_en    = 1'b0;
        w_commit    = 1'b0;
        if (I_VALID) begin
            case (r_state)
                IDLE: begin
                    if (I == START_BIT) begin
                        w_state_nxt = DATA;
                        w_acc_clear = 1'b1;
                    end
                end
                DATA: begin
                    w_acc_en = 1'b1;
                    if (r_cnt == C_LAST_BIT) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
`ifdef PARITY_RX_STOP_CHK_EN
                    w_state_nxt = STOP;
`else
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
`endif
                end
                STOP: begin
`ifdef PARITY_RX_STOP_CHK_EN
                    // A bad stop bit still closes the frame; no resync hunt
                    w_commit    = 1'b1;
`endif
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Bit counter and shift register: data bit n lands in word bit n
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (I_VALID) begin
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (r_state == DATA) begin
                r_shift[r_cnt] <= I;
                r_cnt          <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PARITY_RX_STOP_CHK_EN
    logic r_perr_int;

    // Parity verdict captured in the parity slot, consumed at the stop slot
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_perr_int <= 1'b0;
        end else if (I_VALID && (r_state == PARITY)) begin
            r_perr_int <= w_acc_q ^ I;
        end
    end

    assign w_perr_commit = r_perr_int;
    assign w_ferr_commit = (I != STOP_BIT);
`else
    // Commit happens in the parity slot itself, so the verdict is live
    assign w_perr_commit = w_acc_q ^ I;
    assign w_ferr_commit = 1'b0;
`endif

    // One-deep output register: load when free or being emptied this cycle,
    // otherwise drop the frame and remember it in the sticky overrun flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_commit) begin
                if (!r_valid || O_READY) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                    r_perr  <= w_perr_commit;
                    r_ferr  <= w_ferr_commit;
                end else begin
                    r_ovr   <= 1'b1;
                end
            end else if (r_valid && O_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign O_DATA  = r_data;
    assign O_VALID = r_valid;
    assign O_PERR  = r_perr;
    assign O_FERR  = r_ferr;
    assign O_OVR   = r_ovr;

endmodule : parity_frame_rx
`default_nettype wire
